load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// Sits between the CPU execute stage and Data_Memory; sole driver of Data_Memory's MemWrite/MemRead/read_address/Write_data.
// Accepts one RV32I load/store per handshake; performs byte/halfword lane select + sign/zero extension on loads.
// Data_Memory is word-granular (no byte enables): SB/SH done as read-modify-write. Misaligned/out-of-range -> error, no memory access.
// PARAMETERS
// MEM_WORDS   64   number of 32-bit words in Data_Memory; word index >= MEM_WORDS is out of range
// PORTS
// clk           in   1   system clock, all state on rising edge
// reset         in   1   asynchronous, active-low reset
// req_valid     in   1   core request valid
// req_ready     out  1   LSU can accept (high only in IDLE)
// req_we        in   1   1=store, 0=load
// req_funct3    in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// req_addr      in   32  byte address
// req_wdata     in   32  store data (low byte/half used for SB/SH)
// resp_valid    out  1   one-cycle pulse: request complete
// resp_rdata    out  32  extended load data, valid with resp_valid (0 for stores/errors)
// resp_err      out  1   misaligned, out-of-range or illegal funct3, valid with resp_valid
// MemWrite      out  1   Data_Memory write strobe
// MemRead       out  1   Data_Memory read strobe
// read_address  out  32  Data_Memory word index = req_addr[31:2]
// Write_data    out  32  Data_Memory write word
// MemData_out   in   32  Data_Memory read word, valid the cycle after MemRead
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE; req_ready=1 once released; resp_valid=0, resp_err=0, resp_rdata=0,
//   MemWrite=0, MemRead=0, read_address=0, Write_data=0, internal regs 0. Reset mid-op aborts it, no strobe survives.
// - Accept on req_valid&&req_ready (cycle A): latch addr, funct3, we, wdata. req_valid ignored outside IDLE.
// - Checks at accept: H/HU need addr[0]=0; W needs addr[1:0]=0; addr[31:2]>=MEM_WORDS -> error;
//   funct3 011/110/111, or store with 100/101 -> error. Error path: A+1 RESP with resp_err=1, strobes never assert.
// - States: IDLE, RD, CAP, WR, RESP. Strobes decoded from state: MemRead=1 only in RD, MemWrite=1 only in WR.
// - Load:  IDLE(A) -> RD(A+1) -> CAP(A+2, latch MemData_out) -> RESP(A+3) -> IDLE(A+4).
// - SW:    IDLE(A) -> WR(A+1, Write_data=wdata) -> RESP(A+2) -> IDLE.
// - SB/SH: IDLE(A) -> RD -> CAP(merge wdata byte/half into lane addr[1:0]/addr[1], other lanes preserved) -> WR -> RESP(A+4).
// - Lane select (little-endian): byte = word[8*addr[1:0]+:8]; half = word[16*addr[1]+:16].
//   LB/LH sign-extend, LBU/LHU zero-extend to 32, LW pass-through.
// - read_address held stable from RD through WR; Write_data stable throughout WR.
// - resp_valid exactly one cycle per accepted request; no back-to-back accept (next accept earliest cycle after RESP).
// - No wrap-around: addresses outside range never alias into memory.
// TESTING
// 1 SW addr 0x00 wdata DEADBEEF, then LW 0x00 -> MemWrite one cycle at word 0; resp_rdata=DEADBEEF at A+3, resp_err=0.
// 2 Mem word 5 = CAFEBABE; LB 0x17 -> FFFFFFCA; LBU 0x17 -> 000000CA; LH 0x16 -> FFFFCAFE; LHU 0x14 -> 0000BABE.
// 3 Word 5 = CAFEBABE; SB 0x15 wdata 0x11 -> RD,CAP,WR sequence, Write_data=CAFE11BE; SH 0x16 wdata 0x1234 -> 1234BABE.
// 4 LW 0x02, LH 0x03, SW 0x101 (MEM_WORDS=64) -> resp_err=1 at A+1, MemRead/MemWrite stay 0, memory unchanged.
// 5 Assert reset=0 during WR of SB -> MemWrite drops asynchronously, state IDLE, outputs 0, target word unchanged.
// 6 req_valid held high across 3 loads -> each accepted only in IDLE, three single-cycle resp_valid pulses, 4-cycle spacing.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
//   req_valid/req_ready : one request transfers when both are high
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I width/sign code (B, H, W, BU, HU)
//   req_addr            : byte address
//   req_wdata           : store data (low byte/half used for SB/SH)
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : extended load data (0 for stores and errors)
//   resp_err            : misaligned, out-of-range or illegal request
// master = execute stage, slave = load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-granular Data_Memory.
// Handles one RV32I load/store at a time; sub-word stores are done as
// read-modify-write because the memory has no byte enables.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   core         : request/response handshake (slave side)
//   MemWrite     : Data_Memory write strobe (only in WR)
//   MemRead      : Data_Memory read strobe (only in RD)
//   read_address : Data_Memory word index (req_addr[31:2])
//   Write_data   : Data_Memory write word
//   MemData_out  : Data_Memory read word, valid the cycle after MemRead
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    core,
  output logic                MemWrite,
  output logic                MemRead,
  output logic [31:0]         read_address,
  output logic [31:0]         Write_data,
  input  logic [31:0]         MemData_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

  logic [2:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [29:0] r_widx;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_accept;
  logic w_misalign;
  logic w_illegal;
  logic w_oor;
  logic w_err;

  // Pick the addressed byte/half out of a memory word and extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  off);
    logic signed [7:0]  v_byte;
    logic signed [15:0] v_half;
    logic [31:0]        v_res;
    v_byte = $signed(word[{off, 3'b000} +: 8]);
    v_half = $signed(off[1] ? word[31:16] : word[15:0]);
    case (funct3)
      3'b000:  v_res = {{24{v_byte[7]}}, v_byte};
      3'b001:  v_res = {{16{v_half[15]}}, v_half};
      3'b100:  v_res = {24'd0, v_byte};
      3'b101:  v_res = {16'd0, v_half};
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  // Replace the addressed byte/half of the old word with store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [2:0]  funct3,
                                             input logic [1:0]  off);
    logic [31:0] v_res;
    v_res = word;
    if (funct3[1:0] == 2'b00) begin
      v_res[{off, 3'b000} +: 8] = wdata[7:0];
    end else if (off[1]) begin
      v_res[31:16] = wdata[15:0];
    end else begin
      v_res[15:0] = wdata[15:0];
    end
    return v_res;
  endfunction

  always_comb begin
    w_misalign = 1'b0;
    w_illegal  = 1'b0;
    case (core.req_funct3)
      3'b000, 3'b100: w_misalign = 1'b0;
      3'b001, 3'b101: w_misalign = core.req_addr[0];
      3'b010:         w_misalign = |core.req_addr[1:0];
      default:        w_illegal  = 1'b1;
    endcase
    // Unsigned widths only exist for loads.
    if (core.req_we && core.req_funct3[2]) w_illegal = 1'b1;
    w_oor = ({2'b00, core.req_addr[31:2]} >= LP_WORDS);
    w_err = w_misalign | w_illegal | w_oor;
  end

  assign w_accept = core.req_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_widx      <= 30'd0;
      r_wdata     <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= core.req_we;
            r_funct3 <= core.req_funct3;
            r_off    <= core.req_addr[1:0];
            r_widx   <= core.req_addr[31:2];
            r_wdata  <= core.req_wdata;
            r_rdata  <= 32'd0;
            r_err    <= w_err;
            if (w_err) begin
              r_state <= S_RESP;
            end else if (core.req_we && core.req_funct3 == 3'b010) begin
              // Full-word store needs no read of the old word.
              r_mem_wdata <= core.req_wdata;
              r_state     <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: r_state <= S_CAP;
        S_CAP: begin
          if (r_we) begin
            r_mem_wdata <= lane_merge(MemData_out, r_wdata, r_funct3, r_off);
            r_state     <= S_WR;
          end else begin
            r_rdata <= lane_extract(MemData_out, r_funct3, r_off);
            r_state <= S_RESP;
          end
        end
        S_WR:    r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  assign MemRead          = (r_state == S_RD);
  assign MemWrite         = (r_state == S_WR);
  assign read_address     = {2'b00, r_widx};
  assign Write_data       = r_mem_wdata;
  assign core.req_ready   = (r_state == S_IDLE);
  assign core.resp_valid  = (r_state == S_RESP);
  assign core.resp_err    = (r_state == S_RESP) && r_err;
  assign core.resp_rdata  = (r_state == S_RESP) ? r_rdata : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] read_address, Write_data;
  logic [31:0] MemData_out = 32'd0;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .core(bus),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .read_address(read_address), .Write_data(Write_data),
    .MemData_out(MemData_out)
  );

  always #5 clk = ~clk;

  // Data_Memory stand-in: synchronous write, registered read.
  logic [31:0] dmem [0:63] = '{default: 32'd0};
  always @(posedge clk) begin
    if (MemWrite && read_address < 32'd64) dmem[read_address[5:0]] <= Write_data;
    if (MemRead) MemData_out <= (read_address < 32'd64) ? dmem[read_address[5:0]] : 32'd0;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        mwe;
    int          midx;
    logic [31:0] mword;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [0:63] = '{default: 32'd0};

  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int acc, output exp_t e);
    int unsigned widx, off, sh;
    logic [31:0] w, b, h, mask;
    logic        e_bad;
    widx = addr >> 2;
    off = addr & 3;
    e_bad = 1'b0;
    if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) e_bad = 1'b1;
    if (we && f3 >= 4) e_bad = 1'b1;
    if ((f3 == 1 || f3 == 5) && (off % 2 != 0)) e_bad = 1'b1;
    if (f3 == 2 && off != 0) e_bad = 1'b1;
    if (widx >= 64) e_bad = 1'b1;
    e.err = e_bad; e.rdata = 32'd0; e.mwe = 1'b0; e.midx = 0; e.mword = 32'd0;
    if (e_bad) begin
      e.cyc = acc + 1;
    end else if (!we) begin
      w = ref_mem[widx];
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
        3'd0: e.rdata = (b >= 128) ? b + 32'hFFFFFF00 : b;
        3'd1: e.rdata = (h >= 32768) ? h + 32'hFFFF0000 : h;
        3'd4: e.rdata = b;
        3'd5: e.rdata = h;
        default: e.rdata = w;
      endcase
      e.cyc = acc + 3;
    end else begin
      e.mwe = 1'b1; e.midx = int'(widx);
      if (f3 == 2) begin
        e.mword = wdata; e.cyc = acc + 2;
      end else begin
        sh = (f3 == 0) ? 8 * off : 16 * (off / 2);
        mask = ((f3 == 0) ? 32'hFF : 32'hFFFF) << sh;
        e.mword = (ref_mem[widx] & ~mask) | ((wdata << sh) & mask);
        e.cyc = acc + 4;
      end
    end
  endtask

  // ---------------- compare process ----------------
  int          rd_cnt = 0, wr_cnt = 0, acc_cnt = 0, resp_cnt = 0;
  int          last_acc_cyc = 0, last_resp_cyc = 0;
  logic [31:0] last_rdata = 0, last_wr_data = 0, last_wr_addr = 0;
  logic        last_err = 0;
  int          resp_hist[$];

  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    if (reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        void'(q.pop_front());
      end
      exp_v = (q.size() > 0 && q[0].cyc == cyc);
      chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, exp_v});
      if (exp_v) begin
        e = q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        if (e.mwe) ref_mem[e.midx] = e.mword;
      end
      if (bus.resp_valid) begin
        resp_cnt++; last_resp_cyc = cyc; last_rdata = bus.resp_rdata; last_err = bus.resp_err;
        resp_hist.push_back(cyc);
      end
      if (MemRead) rd_cnt++;
      if (MemWrite) begin
        wr_cnt++; last_wr_data = Write_data; last_wr_addr = read_address;
      end
      if (bus.req_valid && bus.req_ready) begin
        model_op(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata, cyc, e);
        q.push_back(e);
        acc_cnt++; last_acc_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bit ok;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (q.size() > 0) begin
      chk("resp_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    issue(we, f3, addr, wdata);
    wait_done();
  endtask

  int r0, w0, a0, c0;
  bit seen;

  initial begin
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rst_memread", {31'd0, MemRead}, 32'd0);
    chk("rst_read_address", read_address, 32'd0);
    chk("rst_write_data", Write_data, 32'd0);
    reset = 1'b1;
    #1 chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // 1: SW then LW word 0
    w0 = wr_cnt;
    do_req(1'b1, 3'b010, 32'h0, 32'hDEADBEEF);
    chk("sw_write_cycles", wr_cnt - w0, 32'd1);
    chk("sw_write_addr", last_wr_addr, 32'd0);
    chk("sw_latency", last_resp_cyc - last_acc_cyc, 32'd2);
    do_req(1'b0, 3'b010, 32'h0, 32'h0);
    chk("lw_data", last_rdata, 32'hDEADBEEF);
    chk("lw_err", {31'd0, last_err}, 32'd0);
    chk("lw_latency", last_resp_cyc - last_acc_cyc, 32'd3);

    // 2: lane select / extension on CAFEBABE
    do_req(1'b1, 3'b010, 32'h14, 32'hCAFEBABE);
    do_req(1'b0, 3'b000, 32'h17, 32'h0);
    chk("lb_0x17", last_rdata, 32'hFFFFFFCA);
    do_req(1'b0, 3'b100, 32'h17, 32'h0);
    chk("lbu_0x17", last_rdata, 32'h000000CA);
    do_req(1'b0, 3'b001, 32'h16, 32'h0);
    chk("lh_0x16", last_rdata, 32'hFFFFCAFE);
    do_req(1'b0, 3'b101, 32'h14, 32'h0);
    chk("lhu_0x14", last_rdata, 32'h0000BABE);

    // 3: read-modify-write stores
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 3'b000, 32'h15, 32'h00000011);
    chk("sb_write_data", last_wr_data, 32'hCAFE11BE);
    chk("sb_reads", rd_cnt - r0, 32'd1);
    chk("sb_writes", wr_cnt - w0, 32'd1);
    chk("sb_latency", last_resp_cyc - last_acc_cyc, 32'd4);
    do_req(1'b1, 3'b010, 32'h14, 32'hCAFEBABE);
    do_req(1'b1, 3'b001, 32'h16, 32'h00001234);
    chk("sh_write_data", last_wr_data, 32'h1234BABE);
    chk("sh_mem", dmem[5], 32'h1234BABE);
    chk("sh_mem_model", dmem[5], ref_mem[5]);

    // 4: error paths never touch memory
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b0, 3'b010, 32'h02, 32'h0);
    chk("lw_mis_err", {31'd0, last_err}, 32'd1);
    chk("lw_mis_latency", last_resp_cyc - last_acc_cyc, 32'd1);
    do_req(1'b0, 3'b001, 32'h03, 32'h0);
    chk("lh_mis_err", {31'd0, last_err}, 32'd1);
    do_req(1'b1, 3'b010, 32'h101, 32'h55555555);
    chk("sw_oor_err", {31'd0, last_err}, 32'd1);
    do_req(1'b1, 3'b100, 32'h00, 32'h55555555);
    chk("st_bu_err", {31'd0, last_err}, 32'd1);
    do_req(1'b0, 3'b011, 32'h00, 32'h0);
    chk("ld_f3_011_err", {31'd0, last_err}, 32'd1);
    chk("err_rdata", last_rdata, 32'd0);
    chk("err_no_reads", rd_cnt - r0, 32'd0);
    chk("err_no_writes", wr_cnt - w0, 32'd0);
    chk("err_mem0", dmem[0], 32'hDEADBEEF);

    // 5: reset during the write of an SB
    do_req(1'b1, 3'b010, 32'h14, 32'hCAFEBABE);
    issue(1'b1, 3'b000, 32'h15, 32'h00000055);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (MemWrite) begin seen = 1; break; end
    end
    chk("sb_reached_wr", {31'd0, seen}, 32'd1);
    #1 reset = 1'b0;
    #1;
    q.delete();
    chk("abort_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("abort_memread", {31'd0, MemRead}, 32'd0);
    chk("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("abort_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("abort_resp_rdata", bus.resp_rdata, 32'd0);
    chk("abort_read_address", read_address, 32'd0);
    chk("abort_write_data", Write_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_mem5", dmem[5], 32'hCAFEBABE);
    do_req(1'b0, 3'b010, 32'h14, 32'h0);
    chk("abort_lw5", last_rdata, 32'hCAFEBABE);

    // 6: req_valid held high across three loads
    a0 = acc_cnt; c0 = resp_cnt;
    resp_hist.delete();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (9) @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_done();
    chk("held_accepts", acc_cnt - a0, 32'd3);
    chk("held_resps", resp_cnt - c0, 32'd3);
    if (resp_hist.size() == 3) begin
      chk("held_spacing1", resp_hist[1] - resp_hist[0], 32'd4);
      chk("held_spacing2", resp_hist[2] - resp_hist[1], 32'd4);
    end else begin
      chk("held_resp_count", resp_hist.size(), 32'd3);
    end
    chk("held_data", last_rdata, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
